cordic_phase_gen: RTL and testbench
===================================

# cordic_phase_gen

Upstream angle source for `cordic_engine`. Generates a sequence of Q2.29 radian angles by phase accumulation, wrapped into [-π, π), and drives them with a one-cycle valid strobe. It connects directly to the engine's `angle_in` and `input_valid` inputs, so the angles are used for NCO-style sine/cosine synthesis and sweep tests. Burst length, start phase, phase step and output rate are all runtime-programmable.

## Interface
- `WIDTH`, default 32: angle and step width, signed.
- `FRAC`, default 29: fractional bits (Q2.29).
- `CNT_W`, default 16: width of the burst counter.
- `DIV_W`, default 8: width of the rate divider.

Ports:
- `clk`  in  1: single clock. All logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: starts a run. Sampled in IDLE only.
- `stop`  in  1: aborts a run. Sampled in RUN.
- `phase_init`  in  WIDTH: signed Q2.29 start angle. Captured on `start`.
- `phase_step`  in  WIDTH: signed Q2.29 increment per output. Captured on `start`.
- `burst_len`  in  CNT_W: number of angles to emit. 0 means continuous. Captured on `start`.
- `rate_div`  in  DIV_W: emit one angle every `rate_div`+1 cycles. Captured on `start`.
- `angle_out`  out  WIDTH: Q2.29 angle. Connects to the engine's `angle_in`.
- `angle_valid`  out  1: one-cycle strobe. Connects to the engine's `input_valid`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when a finite burst completes.

## Operation
- Constants:
  - PI_Q = 1686629713 (round(π·2^29)).
  - TWO_PI_Q = 3373259426.
- Wrap rule, applied once, in 33-bit signed arithmetic:
  - If x ≥ PI_Q, then x − TWO_PI_Q.
  - Else if x < −PI_Q, then x + TWO_PI_Q.
  - Else x unchanged.
- The single wrap is sufficient because:
  - Every `phase_init` in [-4, 4) lands in [-π, π).
  - acc + step stays within (−2π, 2π).
- Step saturation: a captured `phase_step` ≥ PI_Q becomes PI_Q−1; a step ≤ −PI_Q becomes −(PI_Q−1).
- FSM states: IDLE and RUN.
  - **IDLE, `start`=1 and `stop`=0:**
    - acc ← wrap(phase_init); step ← sat(phase_step).
    - Latch `burst_len` and `rate_div`.
    - cnt ← 0, div ← 0. Go to RUN.
  - **RUN, `stop`=1:** go to IDLE. No emission that cycle, no `done`. `stop` beats a coincident emission.
  - **RUN, div == rate_div:**
    - `angle_out` ← acc; `angle_valid` ← 1.
    - acc ← wrap(acc+step); cnt ← cnt+1; div ← 0.
    - If latched burst_len ≠ 0 and cnt+1 == burst_len: `done` ← 1, go to IDLE.
  - **RUN, otherwise:** div ← div+1.
- `start` is ignored while in RUN. In IDLE, `start` and `stop` together leave the block in IDLE.
- In continuous mode cnt saturates at its maximum and never triggers `done`.
- Input changes after the `start` capture have no effect on the run in progress.

## Timing
- Reset values:
  - `angle_out`=0, `angle_valid`=0, `busy`=0, `done`=0.
  - State IDLE; acc, step, cnt, div all 0.
- All outputs are registered.
- With `start` sampled at edge k:
  - `busy`=1 from edge k.
  - First `angle_valid` is registered at edge k+1+rate_div.
  - Subsequent strobes follow every rate_div+1 edges.
- `done` is registered at the same edge as the final `angle_valid`. `busy` drops at that same edge.
- `angle_out` holds its last value while `angle_valid`=0.
- A new `start` is accepted on the first cycle after `busy` falls.
- Asserting `rst` mid-run forces every output to its reset value immediately, without waiting for a clock. After release, the block sits in IDLE.
- The downstream engine accepts one angle per cycle, so there is no backpressure.

## Structure
- `cordic_pkg` holds:
  - PI_Q, TWO_PI_Q, WIDTH/FRAC defaults.
  - The FSM state typedef (IDLE, RUN).
- Sub-module `cordic_phase_wrap`: combinational 33-bit wrap function. It is instantiated twice, once for the init path and once for the accumulate path.

## Test plan
- **Basic burst:** init 0, step 134217728 (0.25 rad), burst 4, rate 0 → four consecutive strobes with 0, 134217728, 268435456, 402653184; `done` on the 4th strobe; `busy` low afterwards.
- **Positive wrap:** init 1686629712, step 1, burst 2 → 1686629712, then −1686629713.
- **Init and step conditioning:**
  - init 2146946777 (3.999 rad) → first angle −1226312649.
  - step 0x7FFFFFFF → captured step 1686629712.
- **Rate divider:** rate_div 3, burst 3 → strobes at edges k+4, k+8, k+12; `angle_valid` is never high two cycles running.
- **Stop mid-run:** burst 0, `stop` asserted after the 5th strobe → no further strobes, `busy` low the next edge, `done` never asserted; a new `start` then restarts from the new `phase_init`.
- **Reset mid-run:** `rst` pulsed between clock edges during RUN → outputs zero asynchronously; no strobes until the next `start`.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and state type for the CORDIC angle source.
// Angles are signed Q2.29 radians; the pi constants are sized for 33-bit wrap arithmetic.
package cordic_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 29;
  localparam int CNT_W_DEF = 16;
  localparam int DIV_W_DEF = 8;

  localparam logic signed [32:0] PI_Q     = 33'sd1686629713;
  localparam logic signed [32:0] TWO_PI_Q = 33'sd3373259426;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cordic_phase_wrap.sv
// Folds a one-bit-wider signed angle back into [-pi, pi) with a single +/- 2*pi correction.
// The input must lie in (-2*pi, 2*pi), or be a raw Q2.29 value in [-4, 4).
module cordic_phase_wrap
  import cordic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH:0]   x,
  output logic signed [WIDTH-1:0] y
);

  localparam int XW = WIDTH + 1;
  localparam logic signed [XW-1:0] PI_W     = XW'(PI_Q);
  localparam logic signed [XW-1:0] TWO_PI_W = XW'(TWO_PI_Q);

  always_comb begin
    y = WIDTH'(x);
    if (x >= PI_W) begin
      y = WIDTH'(x - TWO_PI_W);
    end else if (x < -PI_W) begin
      y = WIDTH'(x + TWO_PI_W);
    end
  end

endmodule

// File: rtl/cordic_phase_gen.sv
// Phase-accumulating angle source feeding cordic_engine: emits wrapped Q2.29 angles
// with a one-cycle valid strobe, programmable burst length, start phase, step and rate.
module cordic_phase_gen
  import cordic_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic signed [WIDTH-1:0] phase_init,
  input  logic signed [WIDTH-1:0] phase_step,
  input  logic        [CNT_W-1:0] burst_len,
  input  logic        [DIV_W-1:0] rate_div,
  output logic signed [WIDTH-1:0] angle_out,
  output logic                    angle_valid,
  output logic                    busy,
  output logic                    done
);

  // The pi constants and the wrap rule assume one sign bit plus two integer bits.
  if (WIDTH - FRAC != 3) begin : g_format_check
    $error("cordic_phase_gen: WIDTH - FRAC must be 3 (Q2.x format)");
  end

  localparam logic signed [WIDTH-1:0] PI_S     = WIDTH'(PI_Q);
  localparam logic signed [WIDTH-1:0] STEP_MAX = WIDTH'(PI_Q - 33'sd1);

  state_t                  state;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] step;
  logic        [CNT_W-1:0] cnt;
  logic        [CNT_W-1:0] burst_q;
  logic        [DIV_W-1:0] div;
  logic        [DIV_W-1:0] rate_q;

  logic signed [WIDTH-1:0] step_sat;
  logic signed [WIDTH-1:0] init_wrapped;
  logic signed [WIDTH:0]   init_ext;
  logic signed [WIDTH:0]   acc_sum;
  logic signed [WIDTH-1:0] acc_next;
  logic        [CNT_W-1:0] cnt_inc;
  logic                    burst_end;

  // Keeping |step| below pi is what guarantees acc + step never needs a second wrap.
  always_comb begin
    step_sat = phase_step;
    if (phase_step >= PI_S) begin
      step_sat = STEP_MAX;
    end else if (phase_step <= -PI_S) begin
      step_sat = -STEP_MAX;
    end
  end

  assign init_ext  = {phase_init[WIDTH-1], phase_init};
  assign acc_sum   = {acc[WIDTH-1], acc} + {step[WIDTH-1], step};
  assign cnt_inc   = cnt + CNT_W'(1);
  assign burst_end = (burst_q != '0) && (cnt_inc == burst_q);

  cordic_phase_wrap #(
    .WIDTH(WIDTH)
  ) u_init_wrap (
    .x(init_ext),
    .y(init_wrapped)
  );

  cordic_phase_wrap #(
    .WIDTH(WIDTH)
  ) u_acc_wrap (
    .x(acc_sum),
    .y(acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      step        <= '0;
      cnt         <= '0;
      burst_q     <= '0;
      div         <= '0;
      rate_q      <= '0;
      angle_out   <= '0;
      angle_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      angle_valid <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            acc     <= init_wrapped;
            step    <= step_sat;
            burst_q <= burst_len;
            rate_q  <= rate_div;
            cnt     <= '0;
            div     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // An abort wins over an emission due on the same edge.
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (div == rate_q) begin
            angle_out   <= acc;
            angle_valid <= 1'b1;
            acc         <= acc_next;
            div         <= '0;
            if (cnt != '1) begin
              cnt <= cnt_inc;
            end
            if (burst_end) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            div <= div + DIV_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed self-checking bench for cordic_phase_gen with hand-computed Q2.29 angles.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_cordic_phase_gen;

  logic               clk;
  logic               rst;
  logic               start;
  logic               stop;
  logic signed [31:0] phase_init;
  logic signed [31:0] phase_step;
  logic        [15:0] burst_len;
  logic        [7:0]  rate_div;
  logic signed [31:0] angle_out;
  logic               angle_valid;
  logic               busy;
  logic               done;

  int vectors;
  int miscompares;
  logic signed [31:0] exp_angle;
  logic signed [31:0] exp_tab [0:7];

  cordic_phase_gen #(
    .WIDTH(32),
    .FRAC (29),
    .CNT_W(16),
    .DIV_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .phase_init (phase_init),
    .phase_step (phase_step),
    .burst_len  (burst_len),
    .rate_div   (rate_div),
    .angle_out  (angle_out),
    .angle_valid(angle_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input logic e_valid, input logic signed [31:0] e_angle,
                            input logic e_done, input logic e_busy);
    checkOutput({tag, " valid"}, {31'd0, angle_valid}, {31'd0, e_valid});
    checkOutput({tag, " angle"}, angle_out, e_angle);
    checkOutput({tag, " done"},  {31'd0, done},  {31'd0, e_done});
    checkOutput({tag, " busy"},  {31'd0, busy},  {31'd0, e_busy});
  endtask

  // Start is sampled at edge k; inputs are then scrambled to prove they were captured.
  task automatic applyStimulus(input logic signed [31:0] init, input logic signed [31:0] stp,
                               input logic [15:0] burst, input logic [7:0] rate);
    @(negedge clk);
    phase_init = init;
    phase_step = stp;
    burst_len  = burst;
    rate_div   = rate;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    phase_init = 32'sd19088743;
    phase_step = -32'sd99;
    burst_len  = 16'd7;
    rate_div   = 8'd5;
  endtask

  // Runs a finite burst and checks every cycle from edge k to one past the done edge.
  task automatic playBurst(input string name, input logic signed [31:0] init,
                           input logic signed [31:0] stp, input int n_exp, input int rate);
    int period;
    int total;
    logic strobe;
    logic last;
    period = rate + 1;
    total  = period * n_exp;
    applyStimulus(init, stp, 16'(n_exp), 8'(rate));
    for (int n = 0; n <= total + 1; n++) begin
      @(negedge clk);
      strobe = (n > 0) && (n % period == 0) && (n <= total);
      last   = strobe && (n == total);
      if (strobe) exp_angle = exp_tab[n / period - 1];
      checkCycle($sformatf("%s n%0d", name, n), strobe, exp_angle, last, n < total);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_angle   = 0;
    rst         = 1'b1;
    start       = 1'b0;
    stop        = 1'b0;
    phase_init  = 0;
    phase_step  = 0;
    burst_len   = 0;
    rate_div    = 0;
    #2;
    checkCycle("reset", 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkCycle("post reset", 1'b0, 0, 1'b0, 1'b0);

    // Basic burst, 0.25 rad steps.
    exp_tab[0] = 0;
    exp_tab[1] = 134217728;
    exp_tab[2] = 268435456;
    exp_tab[3] = 402653184;
    playBurst("basic", 0, 134217728, 4, 0);

    // Positive wrap across +pi.
    exp_tab[0] = 1686629712;
    exp_tab[1] = -1686629713;
    playBurst("poswrap", 1686629712, 1, 2, 0);

    // Init wrap plus positive step saturation to pi-1.
    exp_tab[0] = -1226312649;
    exp_tab[1] = 460317063;
    playBurst("initsat", 2146946777, 32'sh7FFFFFFF, 2, 0);

    // Negative step saturation, then wrap across -pi.
    exp_tab[0] = 0;
    exp_tab[1] = -1686629712;
    exp_tab[2] = 2;
    playBurst("negsat", 0, 32'sh80000000, 3, 0);

    // Rate divider: strobes every 4 edges.
    exp_tab[0] = 100;
    exp_tab[1] = 1100;
    exp_tab[2] = 2100;
    playBurst("rate", 100, 1000, 3, 3);

    // Continuous run aborted by stop right when a strobe would be due.
    applyStimulus(-5000, 7, 16'd0, 8'd0);
    @(negedge clk);
    checkCycle("cont n0", 1'b0, exp_angle, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      exp_angle = -5000 + 7 * (n - 1);
      checkCycle($sformatf("cont n%0d", n), 1'b1, exp_angle, 1'b0, 1'b1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkCycle("stop", 1'b0, exp_angle, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkCycle($sformatf("stopped %0d", n), 1'b0, exp_angle, 1'b0, 1'b0);
    end

    // Start with stop in IDLE stays idle.
    phase_init = 777;
    burst_len  = 16'd1;
    rate_div   = 8'd0;
    start      = 1'b1;
    stop       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkCycle("start+stop", 1'b0, exp_angle, 1'b0, 1'b0);

    // Restart after stop picks up the new phase_init.
    exp_tab[0] = 12345;
    playBurst("restart", 12345, 0, 1, 0);

    // Asynchronous reset between edges during a continuous run.
    applyStimulus(1000, 1, 16'd0, 8'd0);
    @(negedge clk);
    checkCycle("rstrun n0", 1'b0, exp_angle, 1'b0, 1'b1);
    for (int n = 1; n <= 2; n++) begin
      @(negedge clk);
      exp_angle = 1000 + (n - 1);
      checkCycle($sformatf("rstrun n%0d", n), 1'b1, exp_angle, 1'b0, 1'b1);
    end
    #1;
    rst = 1'b1;
    #1;
    exp_angle = 0;
    checkCycle("async rst", 1'b0, exp_angle, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      checkCycle($sformatf("after rst %0d", n), 1'b0, exp_angle, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
